mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Round-robin arbiter that shares the 8-to-1, 3-bit data mux between eight requesters. It owns the mux `sel` input and holds a grant across multi-beat transfers. It issues a one-hot grant and a `valid` qualifier for the muxed data toward a single downstream consumer with a `ready` handshake. Fairness is enforced by rotating priority and a per-grant burst limit.

## Interface
- `NUM_REQ`, 8: requester count; fixed to match mux input count.
- `SEL_W`, 3: select width, clog2(NUM_REQ).
- `MAX_BURST`, 4: max beats per grant before forced rotation; legal range 1..8.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  8  `req[i]` = requester i has a beat on mux input `data_i`.
- `last`  in  8  `last[i]` = requester i's current beat is its final beat; sampled only with a beat.
- `ready`  in  1  downstream accepts the beat this cycle.
- `sel`  out  3  registered mux select; drives mux `sel`.
- `grant`  out  8  registered one-hot grant, `grant[sel]` when granted, else 0.
- `valid`  out  1  muxed data is a beat: `granted && req[sel]` (combinational from registered state).

## Operation
- **States:** IDLE, GRANT.
- **Reset (async, any time, including mid-burst):**
  - state=IDLE, sel=0, grant=0, valid=0, ptr=0, beat_cnt=0.
  - Any in-flight burst is abandoned.
- **Priority:** `ptr` (3 bits) is the highest-priority index. Search order is ptr, ptr+1, …, ptr+7 mod 8. The first set `req` wins.
- **IDLE:**
  - If any `req`: load sel=winner, grant=onehot(winner), beat_cnt=0, go GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - A beat occurs when `valid && ready`. On each beat, beat_cnt increments.
  - Release conditions (evaluated at the edge):
    - (a) beat with `last[sel]`;
    - (b) beat with beat_cnt==MAX_BURST-1;
    - (c) `req[sel]`==0, whether or not `ready` is high.
  - On release:
    - ptr=sel+1 mod 8.
    - Re-arbitrate using the new ptr over `req` with bit sel masked off.
    - If a winner exists, load it directly (stay in GRANT, beat_cnt=0, no idle cycle).
    - Otherwise go IDLE with grant=0; sel holds its value.
  - No release: sel, grant, and ptr hold.
- **Requests during GRANT:** requests other than the holder never preempt.
- **Simultaneous last and limit:** single release; ptr advances once.
- **`ready` without `valid`:** ignored.
- **`sel` in IDLE:** don't-care for data. It is held stable to avoid mux toggling.

## Timing
- Grant latency: `req` first sampled high at edge E0 in IDLE gives grant/sel/valid high in the cycle after E0. Minimum 1 cycle.
- Handover between requesters is zero-bubble. The new grant is visible the cycle after the releasing edge.
- Burst throughput: 1 beat/cycle while `req[sel]` and `ready` stay high.
- `valid` depends combinationally on `req` only. There is no combinational path from `ready` to any output.
- Worst-case wait for a requesting port: 7 × MAX_BURST beats plus stall cycles.

## Structure
- **Package `mux_arb_pkg`:**
  - state enum {IDLE, GRANT};
  - localparams NUM_REQ=8, SEL_W=3;
  - function onehot(idx).
- **Sub-module `rr_pick`:** combinational round-robin priority picker.
  - Inputs: `req[7:0]`, `ptr[2:0]`, `mask[7:0]`.
  - Outputs: `idx[2:0]`, `found`.
  - Implemented by rotating the request vector, doing a fixed-priority find, then rotating back.
  - Instantiated once, serving both the IDLE and release paths.
- The mux itself is instantiated alongside at integration level, not inside this block.

## Test plan
- Reset mid-burst (req[2]=1, ready=1, 2 beats done) → grant=0, valid=0, sel=0 in the same cycle as reset rises; after release, req[5] alone is granted, sel=5.
- Single requester: req=8'h08, ready=1, last on 3rd beat → sel=3 one cycle after req; exactly 3 beats; then IDLE, grant=0, ptr=4.
- Round-robin: req=8'hFF held, last=0, ready=1, MAX_BURST=4 → grant sequence 0,1,…,7,0 with 4 beats each and no idle cycles between grants.
- Backpressure: req[6]=1, ready=0 for 5 cycles → valid=1 and grant held; beat_cnt=0; sel=6 stable; on the first ready beat, beat_cnt=1.
- Requester drop: req[1] granted, req[1] falls with ready=0, req[4]=1 → next cycle sel=4 with no beat counted for requester 1; ptr was 2 at re-arbitration.
- Wrap-around: ptr=7, req=8'h81 → requester 7 is granted first; after release, requester 0 is granted; after that, ptr=1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// The requester count is fixed by the 8-to-1 data mux it controls.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates the eligible requests so that ptr lands at bit 0, finds the lowest set bit, then rotates the index back.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    input  logic [NUM_REQ-1:0] i_mask,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_found
);

    logic [NUM_REQ-1:0]   w_eligible;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]     w_pos;

    assign w_eligible = i_req & ~i_mask;
    assign w_dbl      = {w_eligible, w_eligible} >> i_ptr;
    assign w_rot      = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = SEL_W'(i);
            end
        end
    end

    // NUM_REQ is a power of two, so the add wraps modulo NUM_REQ for free.
    assign o_idx   = w_pos + i_ptr;
    assign o_found = |w_eligible;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of the shared 8-to-1 data mux.
// It holds the grant across multi-beat bursts and bounds each burst to MAX_BURST beats.
//
// state | meaning
// IDLE  | no holder; grant=0, sel held at its last value
// GRANT | requester sel owns the mux; beats counted on valid && ready
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_last,
    input  logic               i_ready,
    output logic [SEL_W-1:0]   o_sel,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid
);

    localparam int CNT_W = 4;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_granted;
    logic               w_valid;
    logic               w_beat;
    logic               w_limit;
    logic               w_release;
    logic [SEL_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_pick_mask;
    logic [SEL_W-1:0]   w_idx;
    logic               w_found;

    assign w_granted = (r_state == GRANT);
    assign w_valid   = w_granted & i_req[r_sel];
    assign w_beat    = w_valid & i_ready;
    assign w_limit   = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign w_release = w_granted & (~i_req[r_sel] | (w_beat & (i_last[r_sel] | w_limit)));

    // One picker serves both paths: in GRANT it only matters on release,
    // where the search starts just past the holder and skips the holder.
    assign w_pick_ptr  = w_granted ? r_sel + SEL_W'(1) : r_ptr;
    assign w_pick_mask = w_granted ? onehot(r_sel) : '0;

    rr_pick u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (w_pick_ptr),
        .i_mask  (w_pick_mask),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= GRANT;
                        r_sel      <= w_idx;
                        r_grant    <= onehot(w_idx);
                        r_beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_sel + SEL_W'(1);
                        if (w_found) begin
                            r_sel      <= w_idx;
                            r_grant    <= onehot(w_idx);
                            r_beat_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= '0;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_sel   = r_sel;
    assign o_grant = r_grant;
    assign o_valid = w_valid;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed vector table, hand-written corner sequences,
// and random traffic compared against a behavioural round-robin model.
module tb_mux_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] last;
    logic       ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;

    always #5 clk = ~clk;

    mux_arbiter #(.MAX_BURST(MAXB)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_req   (req),
        .i_last  (last),
        .i_ready (ready),
        .o_sel   (sel),
        .o_grant (grant),
        .o_valid (valid)
    );

    int checks = 0;
    int errors = 0;

    bit m_granted;
    int m_holder;
    int m_ptr;
    int m_beats;

    logic [2:0] obs_sel;
    logic [7:0] obs_grant;
    logic       obs_valid;

    typedef struct {
        logic [7:0] req;
        logic [7:0] last;
        logic       ready;
        logic [2:0] sel;
        logic [7:0] grant;
        logic       valid;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p, input int excl);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (p + k) % 8;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_granted = 1'b0;
        m_holder  = 0;
        m_ptr     = 0;
        m_beats   = 0;
    endtask

    task automatic model_step();
        int w;
        bit beat;
        bit rel;
        if (!m_granted) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) begin
                m_granted = 1'b1;
                m_holder  = w;
                m_beats   = 0;
            end
        end else begin
            beat = req[m_holder] && ready;
            if (beat) m_beats++;
            rel = !req[m_holder] || (beat && (last[m_holder] || m_beats == MAXB));
            if (rel) begin
                m_ptr = (m_holder + 1) % 8;
                w = pick(req, m_ptr, m_holder);
                if (w >= 0) begin
                    m_holder = w;
                    m_beats  = 0;
                end else begin
                    m_granted = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle: inputs just after a rising edge, sample at the falling edge, advance model at the next rising edge.
    task automatic tick(input logic [7:0] r, input logic [7:0] l, input logic rdy);
        req   = r;
        last  = l;
        ready = rdy;
        @(negedge clk);
        obs_sel   = sel;
        obs_grant = grant;
        obs_valid = valid;
        check("model_valid", valid, m_granted && req[m_holder]);
        check("model_grant", grant, m_granted ? (32'd1 << m_holder) : 32'd0);
        check("model_sel", sel, m_holder);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req   = 8'hFF;
        last  = 8'h00;
        ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sel", sel, 0);
        check("rst_grant", grant, 0);
        check("rst_valid", valid, 0);
        req   = 8'h00;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] l;
        logic       rdy;

        tbl[0] = '{8'h08, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0};
        tbl[1] = '{8'h08, 8'h00, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[2] = '{8'h08, 8'h00, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[3] = '{8'h08, 8'h08, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 3'd3, 8'h00, 1'b0};
        tbl[5] = '{8'h09, 8'h00, 1'b1, 3'd3, 8'h00, 1'b0};
        tbl[6] = '{8'h09, 8'h01, 1'b1, 3'd0, 8'h01, 1'b1};
        tbl[7] = '{8'h08, 8'h08, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[8] = '{8'h00, 8'h00, 1'b1, 3'd3, 8'h00, 1'b0};

        model_reset();
        reset = 1'b1;
        req   = 8'h00;
        last  = 8'h00;
        ready = 1'b0;
        #12;

        // Single requester, last on third beat, then ptr=4 steers the next pick.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].req, tbl[i].last, tbl[i].ready);
            check($sformatf("tbl%0d_sel", i), obs_sel, tbl[i].sel);
            check($sformatf("tbl%0d_grant", i), obs_grant, tbl[i].grant);
            check($sformatf("tbl%0d_valid", i), obs_valid, tbl[i].valid);
        end

        // All requesting: bursts of MAXB beats rotate 0..7,0 with no idle cycles.
        do_reset();
        tick(8'hFF, 8'h00, 1'b1);
        for (int k = 1; k <= 36; k++) begin
            tick(8'hFF, 8'h00, 1'b1);
            check("rr_sel", obs_sel, ((k - 1) / MAXB) % 8);
            check("rr_valid", obs_valid, 1);
        end

        // Backpressure: stalls do not count toward the burst limit.
        do_reset();
        tick(8'h40, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(8'h40, 8'h00, 1'b0);
            check("bp_stall_sel", obs_sel, 6);
            check("bp_stall_valid", obs_valid, 1);
        end
        for (int k = 0; k < MAXB; k++) begin
            tick(8'h40, 8'h00, 1'b1);
            check("bp_beat_valid", obs_valid, 1);
        end
        tick(8'h40, 8'h00, 1'b1);
        check("bp_after_grant", obs_grant, 8'h00);

        // Holder drops request under stall; re-arbitration starts from 2 so 4 beats 0.
        do_reset();
        tick(8'h02, 8'h00, 1'b0);
        tick(8'h02, 8'h00, 1'b0);
        check("drop_sel1", obs_sel, 1);
        tick(8'h11, 8'h00, 1'b0);
        check("drop_valid0", obs_valid, 0);
        check("drop_grant_held", obs_grant, 8'h02);
        tick(8'h11, 8'h00, 1'b0);
        check("drop_sel4", obs_sel, 4);
        check("drop_grant4", obs_grant, 8'h10);

        // Wrap-around: ptr=7 with requesters 7 and 0.
        do_reset();
        tick(8'h40, 8'h40, 1'b1);
        tick(8'h40, 8'h40, 1'b1);
        tick(8'h81, 8'h00, 1'b0);
        check("wrap_idle", obs_grant, 8'h00);
        tick(8'h81, 8'h80, 1'b1);
        check("wrap_sel7", obs_sel, 7);
        tick(8'h01, 8'h01, 1'b1);
        check("wrap_sel0", obs_sel, 0);
        tick(8'h03, 8'h00, 1'b0);
        tick(8'h03, 8'h00, 1'b0);
        check("wrap_ptr1", obs_sel, 1);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        tick(8'h04, 8'h00, 1'b1);
        tick(8'h04, 8'h00, 1'b1);
        tick(8'h04, 8'h00, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_grant", grant, 8'h00);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_sel", sel, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick(8'h20, 8'h00, 1'b1);
        tick(8'h20, 8'h00, 1'b1);
        check("post_rst_sel", obs_sel, 5);
        check("post_rst_grant", obs_grant, 8'h20);

        // Random traffic against the model.
        do_reset();
        r = 8'h00;
        for (int n = 0; n < 800; n++) begin
            if ($urandom % 4 == 0) r = 8'($urandom) & 8'($urandom);
            l   = ($urandom % 3 == 0) ? 8'($urandom) : 8'h00;
            rdy = ($urandom % 4 != 0);
            tick(r, l, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
